wb_arbiter: RTL and testbench

Write-side front end of the integer register file. Collects register-write results from up to `numSrc` independent producers (ALU, load unit, multiplier) through per-source one-entry buffers with valid/ready handshakes. Arbitrates them round-robin onto the register file's single write port (`regWriteEnable`/`addrD`/`dataD`). Also exposes an in-flight lookup that decode uses to detect pending writes.

---
 rtl/wb_arbiter_pkg.sv | 6 +
 rtl/wb_arbiter_rr_arbiter.sv | 41 ++++
 rtl/wb_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Register-file geometry shared by the write-back front end and the register file.
package riscvDefs;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_ZERO   = 0;
endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found scanning upward from ptr, wrapping past n-1 back to 0.
module rrArbiter #(
   parameter int n  = 3,
   parameter int IW = (n > 1) ? $clog2(n) : 1
) (
   input  logic [n-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [n-1:0]  grant,
   output logic [IW-1:0] grantIdx,
   output logic          anyGrant
);
   logic          hi_found, lo_found;
   logic [IW-1:0] hi_idx, lo_idx;

   // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned j = 0; j < n; j++) begin
         if (req[j]) begin
            if (!lo_found) begin
               lo_found = 1'b1;
               lo_idx   = IW'(j);
            end
            if (!hi_found && (IW'(j) >= ptr)) begin
               hi_found = 1'b1;
               hi_idx   = IW'(j);
            end
         end
      end
      anyGrant = lo_found;
      grantIdx = hi_found ? hi_idx : lo_idx;
      grant    = '0;
      for (int unsigned j = 0; j < n; j++) begin
         grant[j] = anyGrant && (grantIdx == IW'(j));
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write front end: per-source one-entry buffers, round-robin
// arbitration onto the single write port, and a pending-write lookup for decode.
module wb_arbiter
   import riscvDefs::*;
#(
   parameter int width     = XLEN,
   parameter int addrWidth = REG_ADDR_W,
   parameter int numSrc    = 3
) (
   input  logic                        clock,
   input  logic                        clear,
   input  logic [numSrc-1:0]           srcValid,
   output logic [numSrc-1:0]           srcReady,
   input  logic [numSrc*addrWidth-1:0] srcAddr,
   input  logic [numSrc*width-1:0]     srcData,
   output logic                        regWriteEnable,
   output logic [addrWidth-1:0]        addrD,
   output logic [width-1:0]            dataD,
   input  logic [addrWidth-1:0]        pendAddr,
   output logic                        pendHit
);
   localparam int IW = $clog2(numSrc);

   logic [numSrc-1:0]    full_vec, grant, accept;
   logic [addrWidth-1:0] buf_addr [numSrc];
   logic [width-1:0]     buf_data [numSrc];
   logic [IW-1:0]        grant_idx;
   logic                 any_grant;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic                 we_q, we_d;
   logic [addrWidth-1:0] addr_q, addr_d;
   logic [width-1:0]     data_q, data_d;
   logic [addrWidth-1:0] sel_addr;
   logic                 pend_hit;

   for (genvar i = 0; i < numSrc; i++) begin : g_buf
      logic                 full_q, full_d;
      logic [addrWidth-1:0] baddr_q, baddr_d;
      logic [width-1:0]     bdata_q, bdata_d;

      // A granted buffer frees its slot in the same cycle, so it can refill back-to-back.
      assign srcReady[i] = ~clear & (~full_q | grant[i]);
      assign accept[i]   = srcValid[i] & srcReady[i];
      assign full_vec[i] = full_q;
      assign buf_addr[i] = baddr_q;
      assign buf_data[i] = bdata_q;

      always_comb begin
         full_d  = full_q;
         baddr_d = baddr_q;
         bdata_d = bdata_q;
         if (accept[i]) begin
            full_d  = 1'b1;
            baddr_d = srcAddr[i*addrWidth +: addrWidth];
            bdata_d = srcData[i*width +: width];
         end else if (grant[i]) begin
            full_d = 1'b0;
         end
      end

      always_ff @(posedge clock) begin
         if (clear) begin
            full_q  <= 1'b0;
            baddr_q <= '0;
            bdata_q <= '0;
         end else begin
            full_q  <= full_d;
            baddr_q <= baddr_d;
            bdata_q <= bdata_d;
         end
      end
   end

   rrArbiter #(.n(numSrc), .IW(IW)) u_arb (
      .req      (full_vec),
      .ptr      (rr_ptr_q),
      .grant    (grant),
      .grantIdx (grant_idx),
      .anyGrant (any_grant)
   );

   assign sel_addr = buf_addr[grant_idx];

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      if (any_grant) begin
         rr_ptr_d = (grant_idx == IW'(numSrc - 1)) ? '0 : grant_idx + IW'(1);
         // Writes to x0 consume the buffer but never strobe the register file.
         if (sel_addr != addrWidth'(REG_ZERO)) begin
            we_d   = 1'b1;
            addr_d = sel_addr;
            data_d = buf_data[grant_idx];
         end else begin
            addr_d = '0;
            data_d = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         rr_ptr_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      pend_hit = 1'b0;
      for (int unsigned i = 0; i < numSrc; i++) begin
         if (full_vec[i] && (buf_addr[i] == pendAddr)) pend_hit = 1'b1;
      end
      if (we_q && (addr_q == pendAddr)) pend_hit = 1'b1;
      if (pendAddr == addrWidth'(REG_ZERO)) pend_hit = 1'b0;
   end

   assign regWriteEnable = we_q;
   assign addrD          = addr_q;
   assign dataD          = data_q;
   assign pendHit        = pend_hit;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a behavioural model of
// buffers, round-robin pointer and output stage.
module tb_wb_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int W  = 32;

   logic            clock = 1'b0;
   logic            clear;
   logic [N-1:0]    srcValid;
   logic [N-1:0]    srcReady;
   logic [N*AW-1:0] srcAddr;
   logic [N*W-1:0]  srcData;
   logic            regWriteEnable;
   logic [AW-1:0]   addrD;
   logic [W-1:0]    dataD;
   logic [AW-1:0]   pendAddr;
   logic            pendHit;

   int checks   = 0;
   int failures = 0;

   bit            m_full [N];
   logic [AW-1:0] m_addr [N];
   logic [W-1:0]  m_data [N];
   int            m_ptr;
   bit            m_we;
   logic [AW-1:0] m_ad;
   logic [W-1:0]  m_dd;
   int            m_gidx;
   logic [N-1:0]  m_ready;
   bit            m_pend;
   bit            held [N];

   wb_arbiter #(.width(W), .addrWidth(AW), .numSrc(N)) dut (
      .clock          (clock),
      .clear          (clear),
      .srcValid       (srcValid),
      .srcReady       (srcReady),
      .srcAddr        (srcAddr),
      .srcData        (srcData),
      .regWriteEnable (regWriteEnable),
      .addrD          (addrD),
      .dataD          (dataD),
      .pendAddr       (pendAddr),
      .pendHit        (pendHit)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_full[i] = 1'b0;
         m_addr[i] = '0;
         m_data[i] = '0;
      end
      m_ptr = 0;
      m_we  = 1'b0;
      m_ad  = '0;
      m_dd  = '0;
   endtask

   // Grant goes to the first full buffer met walking forward from the pointer.
   task automatic model_eval();
      m_gidx = -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (m_gidx < 0 && m_full[j]) m_gidx = j;
      end
      for (int i = 0; i < N; i++) m_ready[i] = !clear && (!m_full[i] || m_gidx == i);
      m_pend = m_we && (m_ad == pendAddr);
      for (int i = 0; i < N; i++) if (m_full[i] && m_addr[i] == pendAddr) m_pend = 1'b1;
      if (pendAddr == 0) m_pend = 1'b0;
   endtask

   task automatic sample(input string tag);
      @(negedge clock);
      model_eval();
      chk({tag, "_ready"}, 64'(srcReady), 64'(m_ready));
      chk({tag, "_we"}, 64'(regWriteEnable), 64'(m_we));
      chk({tag, "_addr"}, 64'(addrD), 64'(m_ad));
      chk({tag, "_data"}, 64'(dataD), 64'(m_dd));
      chk({tag, "_pend"}, 64'(pendHit), 64'(m_pend));
   endtask

   task automatic tick();
      @(posedge clock);
      model_eval();
      if (clear) begin
         model_reset();
      end else begin
         if (m_gidx >= 0) begin
            if (m_addr[m_gidx] != 0) begin
               m_we = 1'b1;
               m_ad = m_addr[m_gidx];
               m_dd = m_data[m_gidx];
            end else begin
               m_we = 1'b0;
               m_ad = '0;
               m_dd = '0;
            end
            m_ptr = (m_gidx + 1) % N;
         end else begin
            m_we = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (srcValid[i] && m_ready[i]) begin
               m_full[i] = 1'b1;
               m_addr[i] = srcAddr[i*AW +: AW];
               m_data[i] = srcData[i*W +: W];
            end else if (m_gidx == i) begin
               m_full[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < N; i++) held[i] = srcValid[i] && !m_ready[i];
      #1;
   endtask

   task automatic set_src(input int i, input bit v, input logic [AW-1:0] a, input logic [W-1:0] d);
      srcValid[i]         = v;
      srcAddr[i*AW +: AW] = a;
      srcData[i*W +: W]   = d;
   endtask

   task automatic idle_all();
      for (int i = 0; i < N; i++) set_src(i, 1'b0, '0, '0);
   endtask

   initial begin
      clear    = 1'b1;
      srcValid = '0;
      srcAddr  = '0;
      srcData  = '0;
      pendAddr = '0;
      for (int i = 0; i < N; i++) held[i] = 1'b0;
      model_reset();
      @(posedge clock);
      #1;

      // Reset, then a single write from source 1.
      sample("rst0"); chk("rst0_ready_zero", 64'(srcReady), 64'(0)); tick();
      sample("rst1"); tick();
      clear = 1'b0;
      pendAddr = 5'd5;
      sample("idle"); chk("idle_we", 64'(regWriteEnable), 64'(0)); tick();
      set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
      sample("t1_acc"); tick();
      idle_all();
      sample("t1_buf"); chk("t1_buf_we", 64'(regWriteEnable), 64'(0)); tick();
      sample("t1_wr");
      chk("t1_wr_we", 64'(regWriteEnable), 64'(1));
      chk("t1_wr_addr", 64'(addrD), 64'(5));
      chk("t1_wr_data", 64'(dataD), 64'(32'hDEADBEEF));
      tick();
      sample("t1_done"); chk("t1_done_we", 64'(regWriteEnable), 64'(0)); tick();

      // Three-way contention from a freshly cleared pointer.
      clear = 1'b1; sample("t2_clr"); tick(); clear = 1'b0;
      set_src(0, 1'b1, 5'd1, 32'h11);
      set_src(1, 1'b1, 5'd2, 32'h22);
      set_src(2, 1'b1, 5'd3, 32'h33);
      sample("t2_acc"); tick();
      idle_all();
      sample("t2_g0"); tick();
      sample("t2_w1"); chk("t2_w1_addr", 64'(addrD), 64'(1)); tick();
      sample("t2_w2"); chk("t2_w2_addr", 64'(addrD), 64'(2)); tick();
      sample("t2_w3"); chk("t2_w3_addr", 64'(addrD), 64'(3)); chk("t2_w3_data", 64'(dataD), 64'(32'h33)); tick();
      sample("t2_end"); tick();

      // Write to x0 is consumed without a strobe.
      pendAddr = 5'd0;
      set_src(0, 1'b1, 5'd0, 32'hFFFFFFFF);
      sample("t3_acc"); tick();
      idle_all();
      sample("t3_buf"); chk("t3_ready0", 64'(srcReady[0]), 64'(1)); chk("t3_pend0", 64'(pendHit), 64'(0)); tick();
      sample("t3_out"); chk("t3_out_we", 64'(regWriteEnable), 64'(0)); tick();
      sample("t3_post"); chk("t3_post_we", 64'(regWriteEnable), 64'(0)); tick();

      // Back-to-back streaming from source 2.
      pendAddr = 5'd9;
      for (int k = 0; k < 8; k++) begin
         set_src(2, 1'b1, 5'd9, 32'(k));
         sample("t4_stream");
         chk("t4_ready2", 64'(srcReady[2]), 64'(1));
         if (k >= 2) chk("t4_data", 64'(dataD), 64'(k - 2));
         tick();
      end
      idle_all();
      sample("t4_tail0"); chk("t4_tail0_data", 64'(dataD), 64'(6)); tick();
      sample("t4_tail1"); chk("t4_tail1_data", 64'(dataD), 64'(7)); chk("t4_tail1_we", 64'(regWriteEnable), 64'(1)); tick();
      sample("t4_end"); chk("t4_end_we", 64'(regWriteEnable), 64'(0)); tick();

      // Source 0 waits behind sources 1 and 2 while holding x7.
      pendAddr = 5'd7;
      set_src(1, 1'b1, 5'd3, 32'hA1);
      set_src(2, 1'b1, 5'd4, 32'hA2);
      sample("t5_a"); tick();
      idle_all();
      set_src(0, 1'b1, 5'd7, 32'h77);
      sample("t5_b"); tick();
      idle_all();
      sample("t5_c"); chk("t5_c_pend7", 64'(pendHit), 64'(1)); tick();
      sample("t5_d"); chk("t5_d_pend7", 64'(pendHit), 64'(1));
      pendAddr = 5'd8; #1; chk("t5_d_pend8", 64'(pendHit), 64'(0));
      pendAddr = 5'd7; #1;
      tick();
      sample("t5_e"); chk("t5_e_we", 64'(regWriteEnable), 64'(1)); chk("t5_e_pend7", 64'(pendHit), 64'(1)); tick();
      sample("t5_f"); chk("t5_f_pend7", 64'(pendHit), 64'(0)); tick();

      // Clear with every buffer occupied.
      set_src(0, 1'b1, 5'd10, 32'hB0);
      set_src(1, 1'b1, 5'd11, 32'hB1);
      set_src(2, 1'b1, 5'd12, 32'hB2);
      sample("t6_acc"); tick();
      idle_all();
      clear = 1'b1;
      sample("t6_clr"); chk("t6_clr_ready", 64'(srcReady), 64'(0)); chk("t6_clr_we", 64'(regWriteEnable), 64'(0)); tick();
      clear = 1'b0;
      pendAddr = 5'd11;
      for (int k = 0; k < 4; k++) begin
         sample("t6_after"); chk("t6_after_we", 64'(regWriteEnable), 64'(0)); chk("t6_after_pend", 64'(pendHit), 64'(0)); tick();
      end

      // Randomized traffic with sources honouring the hold-until-accepted rule.
      for (int c = 0; c < 400; c++) begin
         clear = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < N; i++) begin
            if (!held[i]) begin
               set_src(i, ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 31)), $urandom);
            end
         end
         if ($urandom_range(0, 1) == 1) pendAddr = m_addr[$urandom_range(0, N - 1)];
         else pendAddr = AW'($urandom_range(0, 31));
         sample("rnd");
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
